// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave exposing a bank of 8-bit control registers to fabric logic.
// Address 0 is a read-only ID byte; each committed write emits a one-cycle strobe.
module spi_slave_regfile #(
   parameter int         NUM_REGS  = 16,
   parameter logic [7:0] ID_VALUE  = 8'hA5,
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic                    clk_clk,
   input  logic                    reset_reset_n,
   input  logic                    spi_sclk,
   input  logic                    spi_ss_n,
   input  logic                    spi_mosi,
   output logic                    spi_miso,
   output logic                    spi_miso_oe,
   output logic [8*NUM_REGS-1:0]   regs_out,
   output logic                    wr_valid,
   output logic [6:0]              wr_addr,
   output logic [7:0]              wr_data,
   output logic                    busy,
   output logic [1:0]              state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2
   } state_t;

   // Pin synchronizers plus one history stage for edge detection.
   logic       sclk_meta, sclk_sync, sclk_prev;
   logic       ss_meta, ss_sync, ss_prev;
   logic       mosi_meta, mosi_sync;
   logic [1:0] sync_vld;
   logic       armed;

   logic       rise, fall, sel_start;

   state_t     state;
   logic [2:0] bit_cnt;
   logic [7:0] rx_sh;
   logic [7:0] tx_sh;
   logic       rw;
   logic [6:0] addr;
   logic       load_skip;
   logic [7:0] regs [1:NUM_REGS-1];

   logic [7:0] rx_next;
   logic [7:0] rd_cmd;
   logic [7:0] rd_nxt;

   function automatic logic [7:0] rdata(input logic [6:0] a);
      logic [7:0] r;
      r = 8'h00;
      if (a == 7'd0) r = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (a == 7'(i)) r = regs[i];
      end
      return r;
   endfunction

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sclk_meta <= 1'b0;
         sclk_sync <= 1'b0;
         sclk_prev <= 1'b0;
         ss_meta   <= 1'b1;
         ss_sync   <= 1'b1;
         ss_prev   <= 1'b1;
         mosi_meta <= 1'b0;
         mosi_sync <= 1'b0;
         sync_vld  <= 2'b00;
         armed     <= 1'b0;
      end else begin
         sclk_meta <= spi_sclk;
         sclk_sync <= sclk_meta;
         sclk_prev <= sclk_sync;
         ss_meta   <= spi_ss_n;
         ss_sync   <= ss_meta;
         ss_prev   <= ss_sync;
         mosi_meta <= spi_mosi;
         mosi_sync <= mosi_meta;
         sync_vld  <= {sync_vld[0], 1'b1};
         // A select already low when reset lifts must be seen high before it can open a frame.
         if (sync_vld[1] && ss_sync) armed <= 1'b1;
      end
   end

   assign rise      = sclk_sync & ~sclk_prev;
   assign fall      = ~sclk_sync & sclk_prev;
   assign sel_start = ss_prev & ~ss_sync;

   assign busy        = ~ss_sync;
   assign spi_miso_oe = ~ss_sync;
   assign state_dbg   = state;

   always_comb begin
      rx_next = {rx_sh[6:0], mosi_sync};
      rd_cmd  = rdata(rx_next[6:0]);
      rd_nxt  = rdata(addr + 7'd1);
   end

   always_comb begin
      regs_out = '0;
      regs_out[7:0] = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) begin
         regs_out[8*i +: 8] = regs[i];
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         rx_sh     <= 8'h00;
         tx_sh     <= 8'h00;
         rw        <= 1'b0;
         addr      <= 7'd0;
         load_skip <= 1'b0;
         spi_miso  <= 1'b0;
         wr_valid  <= 1'b0;
         wr_addr   <= 7'd0;
         wr_data   <= 8'h00;
         for (int i = 1; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      end else begin
         wr_valid <= 1'b0;
         case (state)
            IDLE: begin
               spi_miso <= 1'b0;
               if (armed && sel_start) begin
                  state   <= CMD;
                  bit_cnt <= 3'd0;
                  rx_sh   <= 8'h00;
                  tx_sh   <= 8'h00;
               end
            end
            CMD: begin
               spi_miso <= 1'b0;
               if (ss_sync) begin
                  state <= IDLE;
               end else if (rise) begin
                  rx_sh   <= rx_next;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     rw    <= rx_next[7];
                     addr  <= rx_next[6:0];
                     state <= DATA;
                     if (rx_next[7]) begin
                        tx_sh     <= rd_cmd;
                        spi_miso  <= rd_cmd[7];
                        load_skip <= 1'b1;
                     end
                  end
               end
            end
            DATA: begin
               if (ss_sync) begin
                  // Partial byte is dropped; nothing commits on an abort.
                  state    <= IDLE;
                  spi_miso <= 1'b0;
               end else if (rise) begin
                  rx_sh   <= rx_next;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (!rw) begin
                        if (addr != 7'd0 && int'(addr) < NUM_REGS) begin
                           for (int i = 1; i < NUM_REGS; i++) begin
                              if (addr == 7'(i)) regs[i] <= rx_next;
                           end
                           wr_valid <= 1'b1;
                           wr_addr  <= addr;
                           wr_data  <= rx_next;
                        end
                     end else begin
                        tx_sh     <= rd_nxt;
                        spi_miso  <= rd_nxt[7];
                        load_skip <= 1'b1;
                     end
                     addr <= addr + 7'd1;
                  end
               end else if (fall && rw) begin
                  // The fall right after a load keeps the freshly presented MSB.
                  if (load_skip) begin
                     load_skip <= 1'b0;
                  end else begin
                     tx_sh    <= {tx_sh[6:0], 1'b0};
                     spi_miso <= tx_sh[6];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: bit-banged SPI master, register model
// and expected-strobe queue, checked with immediate assertions.
module tb_spi_slave_regfile;
   localparam int NUM_REGS = 16;

   logic                  clk_clk = 1'b0;
   logic                  reset_reset_n = 1'b0;
   logic                  spi_sclk = 1'b0;
   logic                  spi_ss_n = 1'b1;
   logic                  spi_mosi = 1'b0;
   logic                  spi_miso;
   logic                  spi_miso_oe;
   logic [8*NUM_REGS-1:0] regs_out;
   logic                  wr_valid;
   logic [6:0]            wr_addr;
   logic [7:0]            wr_data;
   logic                  busy;
   logic [1:0]            state_dbg;

   spi_slave_regfile #(
      .NUM_REGS (NUM_REGS),
      .ID_VALUE (8'hA5),
      .RESET_VAL(8'h00)
   ) dut (
      .clk_clk      (clk_clk),
      .reset_reset_n(reset_reset_n),
      .spi_sclk     (spi_sclk),
      .spi_ss_n     (spi_ss_n),
      .spi_mosi     (spi_mosi),
      .spi_miso     (spi_miso),
      .spi_miso_oe  (spi_miso_oe),
      .regs_out     (regs_out),
      .wr_valid     (wr_valid),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .busy         (busy),
      .state_dbg    (state_dbg)
   );

   // Clock / reset
   always #5 clk_clk = ~clk_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_regs [NUM_REGS];
   logic [14:0] exp_q [$];
   logic [14:0] got_q [$];
   logic [7:0]  rd_buf [4];

   always @(negedge clk_clk) begin
      if (wr_valid) got_q.push_back({wr_addr, wr_data});
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] packed_regs();
      logic [127:0] p;
      p = '0;
      p[7:0] = 8'hA5;
      for (int i = 1; i < NUM_REGS; i++) p[8*i +: 8] = exp_regs[i];
      return p;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 8'h00;
      exp_q.delete();
   endtask

   task automatic model_write(input int a, input logic [7:0] d);
      if (a >= 1 && a < NUM_REGS) begin
         exp_regs[a] = d;
         exp_q.push_back({7'(a), d});
      end
   endtask

   task automatic check_strobes(input string tag);
      logic [14:0] g;
      logic [14:0] e;
      check({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         check({tag, "_strobe"}, 128'(g), 128'(e));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   // Driver tasks
   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk_clk);
   endtask

   task automatic spi_bit(input logic b, output logic r);
      spi_mosi = b;
      wait_clk(6);
      r = spi_miso;
      spi_sclk = 1'b1;
      wait_clk(6);
      spi_sclk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
   endtask

   task automatic frame_start();
      spi_ss_n = 1'b0;
      wait_clk(6);
   endtask

   task automatic frame_end();
      wait_clk(6);
      spi_ss_n = 1'b1;
      wait_clk(8);
   endtask

   task automatic spi_write(input logic [6:0] a, input logic [7:0] d, output logic [7:0] miso_seen);
      logic [7:0] tmp;
      frame_start();
      spi_byte({1'b0, a}, tmp);
      spi_byte(d, miso_seen);
      frame_end();
      model_write(int'(a), d);
   endtask

   task automatic spi_read(input logic [7:0] cmd, input int n);
      logic [7:0] tmp;
      frame_start();
      spi_byte(cmd, tmp);
      for (int k = 0; k < n; k++) begin
         spi_byte(8'h00, tmp);
         rd_buf[k] = tmp;
      end
      frame_end();
   endtask

   initial begin
      logic [7:0] rx;
      logic       bit_r;

      model_reset();

      // Reset state
      wait_clk(3);
      check("rst_regs_out", 128'(regs_out), packed_regs());
      check("rst_wr_valid", 128'(wr_valid), 128'(0));
      check("rst_wr_addr", 128'(wr_addr), 128'(0));
      check("rst_wr_data", 128'(wr_data), 128'(0));
      check("rst_miso", 128'(spi_miso), 128'(0));
      check("rst_miso_oe", 128'(spi_miso_oe), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_state", 128'(state_dbg), 128'(0));
      reset_reset_n = 1'b1;
      wait_clk(5);

      // Single write to address 3
      frame_start();
      check("sel_busy", 128'(busy), 128'(1));
      check("sel_oe", 128'(spi_miso_oe), 128'(1));
      check("sel_state_cmd", 128'(state_dbg), 128'(1));
      spi_byte(8'h03, rx);
      check("cmd_miso_zero", 128'(rx), 128'(0));
      spi_byte(8'h5C, rx);
      check("write_miso_zero", 128'(rx), 128'(0));
      frame_end();
      model_write(3, 8'h5C);
      check_strobes("single_write");
      check("single_reg3", 128'(regs_out[31:24]), 128'(8'h5C));
      check("single_regs", 128'(regs_out), packed_regs());
      check("idle_busy", 128'(busy), 128'(0));

      // ID read and out-of-range read
      spi_read(8'h80, 1);
      check("read_id", 128'(rd_buf[0]), 128'(8'hA5));
      spi_read(8'h90, 1);
      check("read_addr16", 128'(rd_buf[0]), 128'(8'h00));
      spi_read(8'h83, 1);
      check("read_reg3", 128'(rd_buf[0]), 128'(8'h5C));
      check_strobes("reads_no_strobe");

      // Burst write running past the top of the bank
      frame_start();
      spi_byte(8'h0E, rx);
      spi_byte(8'h11, rx);
      spi_byte(8'h22, rx);
      spi_byte(8'h33, rx);
      frame_end();
      model_write(14, 8'h11);
      model_write(15, 8'h22);
      model_write(16, 8'h33);
      check_strobes("burst_write");
      check("burst_regs", 128'(regs_out), packed_regs());

      // Burst read of regs 14 and 15
      spi_read(8'h8E, 2);
      check("burst_read_14", 128'(rd_buf[0]), 128'(8'h11));
      check("burst_read_15", 128'(rd_buf[1]), 128'(8'h22));

      // Write to the read-only ID address is dropped
      spi_write(7'd0, 8'h99, rx);
      check_strobes("write_addr0");
      check("addr0_regs", 128'(regs_out), packed_regs());
      spi_read(8'h80, 1);
      check("addr0_id_kept", 128'(rd_buf[0]), 128'(8'hA5));

      // Address wrap on read: 127 -> 0 -> 1
      spi_write(7'd1, 8'h77, rx);
      check_strobes("preload_reg1");
      spi_read(8'hFF, 3);
      check("wrap_addr127", 128'(rd_buf[0]), 128'(8'h00));
      check("wrap_addr0", 128'(rd_buf[1]), 128'(8'hA5));
      check("wrap_addr1", 128'(rd_buf[2]), 128'(8'h77));
      check_strobes("wrap_no_strobe");

      // Abort after 5 bits of a data byte
      frame_start();
      spi_byte(8'h05, rx);
      for (int i = 0; i < 5; i++) spi_bit(1'b1, bit_r);
      frame_end();
      check_strobes("abort");
      check("abort_regs", 128'(regs_out), packed_regs());
      check("abort_state", 128'(state_dbg), 128'(0));
      spi_write(7'd5, 8'h3C, rx);
      check_strobes("after_abort");
      spi_read(8'h85, 1);
      check("after_abort_read", 128'(rd_buf[0]), 128'(8'h3C));

      // Reset in the middle of a read data byte
      frame_start();
      spi_byte(8'h83, rx);
      for (int i = 0; i < 3; i++) spi_bit(1'b0, bit_r);
      wait_clk(5);
      check("pre_reset_miso", 128'(spi_miso), 128'(1));
      check("pre_reset_busy", 128'(busy), 128'(1));
      #2;
      reset_reset_n = 1'b0;
      #1;
      model_reset();
      check("async_rst_miso", 128'(spi_miso), 128'(0));
      check("async_rst_oe", 128'(spi_miso_oe), 128'(0));
      check("async_rst_busy", 128'(busy), 128'(0));
      check("async_rst_regs", 128'(regs_out), packed_regs());
      check("async_rst_state", 128'(state_dbg), 128'(0));
      wait_clk(3);
      reset_reset_n = 1'b1;
      wait_clk(10);
      check("stale_sel_idle", 128'(state_dbg), 128'(0));
      spi_byte(8'h02, rx);
      spi_byte(8'h44, rx);
      wait_clk(6);
      check("stale_sel_state", 128'(state_dbg), 128'(0));
      check_strobes("stale_sel");
      check("stale_sel_regs", 128'(regs_out), packed_regs());
      frame_end();
      spi_write(7'd2, 8'h44, rx);
      check_strobes("fresh_sel");
      check("fresh_sel_regs", 128'(regs_out), packed_regs());
      spi_read(8'h82, 1);
      check("fresh_sel_read", 128'(rd_buf[0]), 128'(8'h44));

      // Final report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
